// File: rtl/arm_mem_access_unit.sv
// Memory stage with a req/ack port: stalls the pipeline until the access completes,
// positions store/load bytes on lanes, detects misalignment/timeouts and holds MEM/WB.
module arm_mem_access_unit #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int LANE_REVERSE = 1,
  parameter int MAX_WAIT     = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ex_valid,
  input  logic [ADDR_W-1:0]                 ex_result,
  input  logic [DATA_W-1:0]                 ex_store_data,
  input  logic                              ex_is_load,
  input  logic                              ex_is_store,
  input  logic [1:0]                        ex_size,
  input  logic                              ex_signed,
  input  logic                              ex_rd_we,
  input  logic                              ex_rd_sel,
  input  logic                              ex_halted,
  input  logic [3:0]                        ex_rd_num,
  output logic                              mem_req,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0] mem_addr,
  output logic [DATA_W/8-1:0]               mem_we,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  input  logic                              mem_ack,
  input  logic                              mem_err,
  output logic                              stall,
  output logic                              fwd_valid,
  output logic [3:0]                        fwd_rd_num,
  output logic [DATA_W-1:0]                 fwd_data,
  output logic                              wb_valid,
  output logic                              wb_rd_we,
  output logic                              wb_rd_sel,
  output logic                              wb_halted,
  output logic [3:0]                        wb_rd_num,
  output logic [DATA_W-1:0]                 wb_load_data,
  output logic [DATA_W-1:0]                 wb_alu_data,
  output logic [1:0]                        wb_fault
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  logic mem_op, mis, aligned_op, load_ok, sbit;
  logic [1:0] fault;
  logic [NB-1:0] we_raw;
  logic [DATA_W-1:0] wdata_raw, ld_raw, ld_ext, alu_ext;
  int unsigned kk, nbytes, lane;

  assign mem_op     = ex_valid & (ex_is_load | ex_is_store);
  assign aligned_op = mem_op & ~mis;
  assign alu_ext    = DATA_W'(ex_result);
  assign mem_addr   = ex_result[ADDR_W-1:OW];

  always_comb begin
    mis = 1'b0;
    case (ex_size)
      2'b01: mis = ex_result[0];
      2'b10: mis = |ex_result[1:0];
      2'b11: mis = (DATA_W == 32) ? 1'b1 : |ex_result[2:0];
      default: mis = 1'b0;
    endcase
  end

  // Byte j of the access window maps to lane L(j); access byte (j-k) is the data byte.
  always_comb begin
    we_raw    = '0;
    wdata_raw = '0;
    ld_raw    = '0;
    ld_ext    = '0;
    sbit      = 1'b0;
    lane      = 0;
    kk        = 32'(ex_result[OW-1:0]);
    nbytes    = 32'd1 << ex_size;
    for (int unsigned j = 0; j < NB; j++) begin
      if (j >= kk && j < kk + nbytes) begin
        lane = (LANE_REVERSE != 0) ? (NB - 1 - j) : j;
        we_raw[lane]                 = 1'b1;
        wdata_raw[lane*8 +: 8]       = ex_store_data[(j-kk)*8 +: 8];
        ld_raw[(j-kk)*8 +: 8]        = mem_rdata[lane*8 +: 8];
      end
    end
    for (int unsigned b = 0; b < NB; b++)
      if (b + 1 == nbytes) sbit = ld_raw[b*8+7];
    for (int unsigned b = 0; b < NB; b++)
      ld_ext[b*8 +: 8] = (b < nbytes) ? ld_raw[b*8 +: 8] : {8{ex_signed & sbit}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mem_req = 1'b0;
    stall   = 1'b0;
    fault   = 2'b00;
    if (mem_op & mis) begin
      fault = 2'b01;
    end else if (aligned_op) begin
      mem_req = 1'b1;
      if (state == S_IDLE) begin
        if (!mem_ack) begin
          stall   = 1'b1;
          state_n = S_WAIT;
          cnt_n   = CW'(1);
        end
      end else if (mem_ack) begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end else if (cnt == CW'(MAX_WAIT)) begin
        fault   = 2'b11;
        state_n = S_IDLE;
        cnt_n   = '0;
      end else begin
        stall = 1'b1;
        cnt_n = cnt + 1'b1;
      end
      if (mem_ack & mem_err) fault = 2'b10;
    end else begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end
    if (rst) begin
      mem_req = 1'b0;
      stall   = 1'b0;
    end
  end

  assign load_ok    = aligned_op & ex_is_load & mem_ack & ~mem_err;
  assign mem_we     = (mem_req & ex_is_store) ? we_raw : '0;
  assign mem_wdata  = wdata_raw;
  assign fwd_valid  = ex_valid & ex_rd_we & ~stall & (fault == 2'b00) & ~rst;
  assign fwd_rd_num = ex_rd_num;
  assign fwd_data   = ex_is_load ? ld_ext : alu_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_rd_we     <= 1'b0;
      wb_rd_sel    <= 1'b0;
      wb_halted    <= 1'b0;
      wb_rd_num    <= '0;
      wb_load_data <= '0;
      wb_alu_data  <= '0;
      wb_fault     <= '0;
    end else if (stall) begin
      wb_valid  <= 1'b0;
      wb_rd_we  <= 1'b0;
      wb_halted <= 1'b0;
      wb_fault  <= '0;
    end else begin
      wb_valid     <= ex_valid;
      wb_rd_we     <= ex_valid & ex_rd_we & (fault == 2'b00);
      wb_rd_sel    <= ex_rd_sel;
      wb_halted    <= ex_valid & ex_halted;
      wb_rd_num    <= ex_rd_num;
      wb_load_data <= load_ok ? ld_ext : '0;
      wb_alu_data  <= alu_ext;
      wb_fault     <= fault;
    end
  end
endmodule

// File: tb/tb_arm_mem_access_unit.sv
// Directed bench: two instances (reversed and natural lane order) share one stimulus.
module tb_arm_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_load, ex_is_store, ex_signed, ex_rd_we, ex_rd_sel, ex_halted;
  logic [31:0] ex_result, ex_store_data, mem_rdata;
  logic [1:0]  ex_size;
  logic [3:0]  ex_rd_num;
  logic        mem_ack, mem_err;

  logic        r_req, r_stall, r_fv, r_wv, r_wwe, r_wsel, r_wh;
  logic [29:0] r_addr;
  logic [3:0]  r_we, r_frn, r_wrn;
  logic [31:0] r_wdata, r_fd, r_wld, r_wad;
  logic [1:0]  r_wf;
  logic        l_req, l_stall, l_fv, l_wv, l_wwe, l_wsel, l_wh;
  logic [29:0] l_addr;
  logic [3:0]  l_we, l_frn, l_wrn;
  logic [31:0] l_wdata, l_fd, l_wld, l_wad;
  logic [1:0]  l_wf;

  int n_cmp = 0;
  int n_err = 0;
  int n_stall;

  always #5 clk = ~clk;

  arm_mem_access_unit #(.DATA_W(32), .ADDR_W(32), .LANE_REVERSE(1), .MAX_WAIT(15)) u_rev (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_size(ex_size), .ex_signed(ex_signed), .ex_rd_we(ex_rd_we), .ex_rd_sel(ex_rd_sel),
    .ex_halted(ex_halted), .ex_rd_num(ex_rd_num), .mem_req(r_req), .mem_addr(r_addr),
    .mem_we(r_we), .mem_wdata(r_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_err(mem_err), .stall(r_stall), .fwd_valid(r_fv), .fwd_rd_num(r_frn),
    .fwd_data(r_fd), .wb_valid(r_wv), .wb_rd_we(r_wwe), .wb_rd_sel(r_wsel),
    .wb_halted(r_wh), .wb_rd_num(r_wrn), .wb_load_data(r_wld), .wb_alu_data(r_wad),
    .wb_fault(r_wf));

  arm_mem_access_unit #(.DATA_W(32), .ADDR_W(32), .LANE_REVERSE(0), .MAX_WAIT(15)) u_le (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_size(ex_size), .ex_signed(ex_signed), .ex_rd_we(ex_rd_we), .ex_rd_sel(ex_rd_sel),
    .ex_halted(ex_halted), .ex_rd_num(ex_rd_num), .mem_req(l_req), .mem_addr(l_addr),
    .mem_we(l_we), .mem_wdata(l_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_err(mem_err), .stall(l_stall), .fwd_valid(l_fv), .fwd_rd_num(l_frn),
    .fwd_data(l_fd), .wb_valid(l_wv), .wb_rd_we(l_wwe), .wb_rd_sel(l_wsel),
    .wb_halted(l_wh), .wb_rd_num(l_wrn), .wb_load_data(l_wld), .wb_alu_data(l_wad),
    .wb_fault(l_wf));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [1:0] sz, input logic sg, input logic rwe);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_result = addr;
    ex_size = sz; ex_signed = sg; ex_rd_we = rwe;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_result = '0; ex_size = 0;
    ex_signed = 0; ex_rd_we = 0; ex_rd_sel = 0; ex_halted = 0; ex_rd_num = 0;
    ex_store_data = '0; mem_rdata = '0; mem_ack = 0; mem_err = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    // Aligned load presented under reset must not reach the bus
    set_op(1, 0, 32'h100, 2'b10, 0, 1);
    @(negedge clk);
    chk("rst_req", r_req, 0);
    chk("rst_stall", r_stall, 0);
    tick(); tick();
    chk("rst_wb_valid", r_wv, 0);
    chk("rst_wb_fault", r_wf, 0);
    chk("rst_wb_alu", r_wad, 0);
    rst = 1'b0;

    // Word load, same-cycle ack
    set_op(1, 0, 32'h100, 2'b10, 0, 1);
    ex_rd_num = 4'd5; mem_rdata = 32'hDEADBEEF; mem_ack = 1;
    @(negedge clk);
    chk("w_stall", r_stall, 0);
    chk("w_req", r_req, 1);
    chk("w_addr", r_addr, 30'h40);
    chk("w_fwd_valid", l_fv, 1);
    chk("w_fwd_rd", l_frn, 5);
    chk("w_fwd_data_le", l_fd, 32'hDEADBEEF);
    tick();
    idle_inputs();
    chk("w_wb_ld_le", l_wld, 32'hDEADBEEF);
    chk("w_wb_ld_rev", r_wld, 32'hEFBEADDE);
    chk("w_wb_valid", r_wv, 1);
    chk("w_wb_fault", r_wf, 0);
    chk("w_wb_rdwe", r_wwe, 1);
    chk("w_wb_rdnum", r_wrn, 5);

    // Byte store 0xA5 @0x203, ack after 3 stall cycles
    set_op(0, 1, 32'h203, 2'b00, 0, 0);
    ex_store_data = 32'h000000A5; ex_halted = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_stall", r_stall, 1);
      chk("st_req", r_req, 1);
      chk("st_we_rev", r_we, 4'b0001);
      chk("st_wdata_rev", r_wdata[7:0], 8'hA5);
      chk("st_we_le", l_we, 4'b1000);
      chk("st_wdata_le", l_wdata[31:24], 8'hA5);
      tick();
      chk("st_bubble_valid", r_wv, 0);
      chk("st_bubble_halt", r_wh, 0);
    end
    mem_ack = 1;
    @(negedge clk);
    chk("st_ack_stall", r_stall, 0);
    tick();
    idle_inputs();
    chk("st_wb_valid", r_wv, 1);
    chk("st_wb_halt", r_wh, 1);
    chk("st_wb_rdwe", r_wwe, 0);
    chk("st_wb_fault", r_wf, 0);

    // Half loads @0x102, signed then unsigned
    set_op(1, 0, 32'h102, 2'b01, 1, 1);
    mem_rdata = 32'h80F01234; mem_ack = 1;
    @(negedge clk);
    chk("hs_fwd_le", l_fd, 32'hFFFF80F0);
    tick();
    chk("hs_wb_le", l_wld, 32'hFFFF80F0);
    chk("hs_wb_rev", r_wld, 32'h00003412);
    ex_signed = 0;
    tick();
    chk("hu_wb_le", l_wld, 32'h000080F0);
    idle_inputs();

    // Misaligned word load
    set_op(1, 0, 32'h101, 2'b10, 0, 1);
    mem_ack = 1;
    @(negedge clk);
    chk("mis_req", r_req, 0);
    chk("mis_stall", r_stall, 0);
    chk("mis_fwd", r_fv, 0);
    tick();
    idle_inputs();
    chk("mis_fault", r_wf, 2'b01);
    chk("mis_rdwe", r_wwe, 0);
    chk("mis_valid", r_wv, 1);

    // Bus error on a load
    set_op(1, 0, 32'h10C, 2'b10, 0, 1);
    mem_rdata = 32'h12345678; mem_ack = 1; mem_err = 1;
    @(negedge clk);
    chk("err_fwd", r_fv, 0);
    tick();
    idle_inputs();
    chk("err_fault", r_wf, 2'b10);
    chk("err_rdwe", r_wwe, 0);
    chk("err_ld", r_wld, 0);

    // Timeout: no ack at all
    set_op(1, 0, 32'h104, 2'b10, 0, 1);
    n_stall = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!r_stall) break;
      n_stall++;
      @(posedge clk);
    end
    chk("to_stall_cycles", n_stall, 15);
    tick();
    chk("to_fault", r_wf, 2'b11);
    chk("to_rdwe", r_wwe, 0);
    chk("to_valid", r_wv, 1);
    // Non-memory op afterwards: request gone, ALU result forwarded
    idle_inputs();
    ex_valid = 1; ex_result = 32'h55; ex_rd_we = 1; ex_rd_num = 4'd9;
    @(negedge clk);
    chk("alu_req", r_req, 0);
    chk("alu_fwd_valid", r_fv, 1);
    chk("alu_fwd_data", r_fd, 32'h55);
    tick();
    chk("alu_wb", r_wad, 32'h55);
    chk("alu_wb_fault", r_wf, 0);
    // Next load with immediate ack completes normally
    idle_inputs();
    set_op(1, 0, 32'h108, 2'b10, 0, 1);
    mem_rdata = 32'h11223344; mem_ack = 1;
    @(negedge clk);
    chk("post_stall", r_stall, 0);
    tick();
    idle_inputs();
    chk("post_ld_le", l_wld, 32'h11223344);
    chk("post_fault", l_wf, 0);

    // Reset during WAIT, then a late ack
    set_op(1, 0, 32'h100, 2'b10, 0, 1);
    tick();
    rst = 1;
    @(negedge clk);
    chk("rw_req", r_req, 0);
    chk("rw_stall", r_stall, 0);
    tick();
    rst = 0;
    idle_inputs();
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rw_idle_stall", r_stall, 0);
    chk("rw_idle_req", r_req, 0);
    tick();
    mem_ack = 0;
    chk("rw_wb_valid", r_wv, 0);
    chk("rw_wb_rdwe", r_wwe, 0);
    chk("rw_wb_ld", r_wld, 0);
    chk("rw_wb_alu", r_wad, 0);
    chk("rw_wb_fault", r_wf, 0);
    chk("rw_wb_halt", r_wh, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
